// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for a single-ported unified memory
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifreq,
    input  logic [31:0] ifaddr,
    output logic [31:0] ifrdata,
    output logic        ifready,
    input  logic        dreq,
    input  logic        dwe,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    output logic [31:0] drdata,
    output logic        dready,
    output logic        mreq,
    output logic        mwe,
    output logic [31:0] maddr,
    output logic [31:0] mwdata,
    input  logic [31:0] mrdata,
    input  logic        mack
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IBUSY = 2'd1,
        ST_DBUSY = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        mreq_q, mreq_d;
    logic        mwe_q, mwe_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] mwdata_q, mwdata_d;
    logic [31:0] ifrdata_q, ifrdata_d;
    logic [31:0] drdata_q, drdata_d;
    logic        ifready_q, ifready_d;
    logic        dready_q, dready_d;

    logic        f_elig;
    logic        d_elig;
    logic        grant_d;
    logic        grant_f;

    // A port is eligible only outside its own ready cycle; data wins unless fetch has waited too long
    always_comb begin
        f_elig  = ifreq & ~ifready_q;
        d_elig  = dreq & ~dready_q;
        grant_d = 1'b0;
        grant_f = 1'b0;
        if (state_q == ST_IDLE) begin
            grant_d = d_elig & (~f_elig | (starve_cnt_q < STARVE_LIM));
            grant_f = f_elig & ~grant_d;
        end
    end

    // Next-state, memory-side request and response-holding registers
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mreq_d       = mreq_q;
        mwe_d        = mwe_q;
        maddr_d      = maddr_q;
        mwdata_d     = mwdata_q;
        ifrdata_d    = ifrdata_q;
        drdata_d     = drdata_q;
        ifready_d    = 1'b0;
        dready_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_d) begin
                    state_d  = ST_DBUSY;
                    mreq_d   = 1'b1;
                    mwe_d    = dwe;
                    maddr_d  = daddr;
                    mwdata_d = dwdata;
                    // Only data grants made while fetch is asking count toward starvation
                    if (ifreq) begin
                        if (starve_cnt_q >= STARVE_LIM) begin
                            starve_cnt_d = STARVE_LIM;
                        end else begin
                            starve_cnt_d = starve_cnt_q + 4'd1;
                        end
                    end else begin
                        starve_cnt_d = 4'd0;
                    end
                end else if (grant_f) begin
                    state_d      = ST_IBUSY;
                    mreq_d       = 1'b1;
                    mwe_d        = 1'b0;
                    maddr_d      = ifaddr;
                    mwdata_d     = 32'd0;
                    starve_cnt_d = 4'd0;
                end
            end
            ST_IBUSY: begin
                if (mack) begin
                    state_d   = ST_IDLE;
                    mreq_d    = 1'b0;
                    mwe_d     = 1'b0;
                    ifrdata_d = mrdata;
                    ifready_d = 1'b1;
                end
            end
            ST_DBUSY: begin
                if (mack) begin
                    state_d  = ST_IDLE;
                    mreq_d   = 1'b0;
                    mwe_d    = 1'b0;
                    // Stores complete without disturbing the last load result
                    if (!mwe_q) begin
                        drdata_d = mrdata;
                    end
                    dready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mreq_d  = 1'b0;
                mwe_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any outstanding memory transaction
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= 4'd0;
            mreq_q       <= 1'b0;
            mwe_q        <= 1'b0;
            maddr_q      <= 32'd0;
            mwdata_q     <= 32'd0;
            ifrdata_q    <= 32'd0;
            drdata_q     <= 32'd0;
            ifready_q    <= 1'b0;
            dready_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mreq_q       <= mreq_d;
            mwe_q        <= mwe_d;
            maddr_q      <= maddr_d;
            mwdata_q     <= mwdata_d;
            ifrdata_q    <= ifrdata_d;
            drdata_q     <= drdata_d;
            ifready_q    <= ifready_d;
            dready_q     <= dready_d;
        end
    end

    assign mreq    = mreq_q;
    assign mwe     = mwe_q;
    assign maddr   = maddr_q;
    assign mwdata  = mwdata_q;
    assign ifrdata = ifrdata_q;
    assign drdata  = drdata_q;
    assign ifready = ifready_q;
    assign dready  = dready_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single-ported unified memory between the pipeline's instruction-fetch (F) and data-memory (M) stages. Each requester holds a request until it receives a one-cycle ready pulse. The F/M stall logic treats "req high and ready low" as stall. Data requests have priority, and a starvation counter guarantees fetch progress. The block registers all memory-side outputs and returns read data through holding registers.

## Interface
- STARVE_MAX, 4: consecutive data grants allowed while a fetch is pending before fetch is forced; legal range 1..15.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low (0 = reset), sampled on clk rising edge.
- ifreq  in  1  fetch request; held with ifaddr stable until ifready.
- ifaddr  in  32  fetch word address.
- ifrdata  out  32  fetched instruction; valid while ifready=1, held afterwards.
- ifready  out  1  one-cycle completion pulse for fetch.
- dreq  in  1  data request; held with dwe/daddr/dwdata stable until dready.
- dwe  in  1  1 = store, 0 = load.
- daddr  in  32  data address.
- dwdata  in  32  store data.
- drdata  out  32  load data; valid while dready=1, held afterwards.
- dready  out  1  one-cycle completion pulse for data.
- mreq  out  1  memory request; held until mack.
- mwe  out  1  memory write enable, qualified by mreq.
- maddr  out  32  memory address.
- mwdata  out  32  memory write data.
- mrdata  in  32  memory read data; valid in the mack cycle.
- mack  in  1  memory completion, one cycle. Never asserted in the cycle mreq first rises.

## Operation
- **States:** IDLE, IBUSY, DBUSY. Encoding is free.
- **Eligibility in IDLE:**
  - The F port is eligible when ifreq=1 and ifready=0.
  - The D port is eligible when dreq=1 and dready=0.
  - A port's request is ignored during the cycle its own ready is high, because the requester advances on that edge.
- **Grant decision in IDLE:**
  - Only one port eligible: grant it.
  - Both eligible, starve_cnt < STARVE_MAX: grant D.
  - Both eligible, starve_cnt == STARVE_MAX: grant F.
- **On grant:**
  - Move to IBUSY or DBUSY.
  - Register mreq=1, maddr, mwe, mwdata. A fetch uses mwe=0 and mwdata=0.
- **starve_cnt (4 bits), updated only on grants:**
  - D grant while ifreq=1: increment, saturating at STARVE_MAX.
  - F grant: clear to 0.
  - D grant while ifreq=0: clear to 0.
- **IBUSY/DBUSY:**
  - Hold all memory outputs until mack=1.
  - On mack: capture mrdata into ifrdata (IBUSY) or drdata (DBUSY, loads only; stores leave drdata unchanged).
  - On mack: pulse the matching ready next cycle, drop mreq, return to IDLE.
- **Robustness:**
  - mack in IDLE is ignored.
  - Requests deasserted mid-transaction do not abort it. The transaction completes and ready still pulses.
- **Reset** (reset=0 at an edge), including mid-transaction:
  - State IDLE, starve_cnt 0.
  - mreq, mwe, ifready, dready 0.
  - maddr, mwdata, ifrdata, drdata 0.
  - An outstanding memory transaction is abandoned. The memory must accept mreq falling without mack.

## Timing
- Request seen at edge t (IDLE, eligible): mreq=1 from t+1.
- mack high in cycle k: ready=1 and data valid in cycle k+1, mreq=0 in cycle k+1.
- Minimum turnaround is 3 cycles from grant edge to ready (memory with 1-cycle ack latency).
- The earliest next grant is the edge ending the ready cycle, so mreq is low for at least one cycle between transactions.
- A request pending in the ready cycle of the other port is eligible at that same edge.
- All outputs are registers; there are no combinational input-to-output paths.

## Test plan
- **Single fetch:**
  - Stimulus: ifreq=1, ifaddr=0x100; memory acks 2 cycles after mreq with mrdata=0x2002_0005.
  - Response: mreq=1/maddr=0x100/mwe=0; ifready pulses exactly once with ifrdata=0x2002_0005.
  - Response: no second grant while ifreq is still high in the ready cycle.
- **Store then load:**
  - Stimulus: dwe=1, daddr=0x40, dwdata=0xDEAD_BEEF, followed by a load from 0x40 (memory model echoes).
  - Response: mwe=1 with correct data on the store; drdata=0xDEAD_BEEF on the load's dready; drdata unchanged after the store.
- **Simultaneous requests:**
  - Stimulus: ifreq=dreq=1 in the same cycle.
  - Response: D granted first, F granted at the edge ending dready; both ready pulses seen, each exactly once.
- **Starvation, STARVE_MAX=4:**
  - Stimulus: dreq is re-requested continuously and ifreq is held at 1.
  - Response: exactly 4 D grants, then an F grant, then D resumes; starve_cnt reads 0 after the F grant.
- **Reset mid-transaction:**
  - Stimulus: assert reset=0 in DBUSY before mack, with a stray mack one cycle later.
  - Response: all outputs 0 after the edge; no dready; the stray mack is ignored; a fresh ifreq after release is granted normally.
- **Slow memory:**
  - Stimulus: mack delayed 10 cycles.
  - Response: mreq, maddr and mwdata stay stable for all 10 cycles; ready pulses in the cycle after mack.
